divisor_4bits: RTL and testbench



---
 rtl/divisor_pkg.sv | 16 +
 rtl/subtrator_nbits.sv | 33 +++
 rtl/divisor_4bits.sv | 160 ++++++++++++++++
 tb/tb_divisor_4bits.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// divisor_pkg
// Shared definitions for the sequential restoring divider: FSM state
// encoding and the default operand width.
package divisor_pkg;

    // Divider control states; encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } div_state_e;

    // Default operand / quotient / remainder width.
    localparam int DIV_W = 4;

endpackage : divisor_pkg

// File: rtl/subtrator_nbits.sv
// subtrator_nbits
// N-bit ripple subtractor built as X + ~Y + 1 from a chain of 1-bit full
// adders. The final carry-out is high when no borrow occurred (X >= Y).
//
// Ports:
//   X        in  N  minuend
//   Y        in  N  subtrahend
//   Diff     out N  X - Y (modulo 2^N)
//   NoBorrow out 1  carry-out of the top full adder (1 when X >= Y)
module subtrator_nbits #(
    parameter int N = 5
) (
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic [N-1:0] Diff,
    output logic         NoBorrow
);

    logic [N:0]   carry;
    logic [N-1:0] y_inv;

    assign y_inv    = ~Y;
    // Carry-in of 1 completes the two's-complement negation of Y.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign Diff[i]    = X[i] ^ y_inv[i] ^ carry[i];
        assign carry[i+1] = (X[i] & y_inv[i]) | (carry[i] & (X[i] ^ y_inv[i]));
    end

    assign NoBorrow = carry[N];

endmodule : subtrator_nbits

// File: rtl/divisor_4bits.sv
// divisor_4bits
// Sequential unsigned restoring divider, one quotient bit per clock.
// A Start accepted in IDLE captures the operands; W trial subtractions
// follow in RUN, then FIN presents a one-cycle Done pulse. Q/R/DivZero
// are updated only on the edge entering FIN and hold otherwise.
//
// Ports:
//   Clk      in  1  clock, rising edge
//   Reset    in  1  asynchronous, active-high reset
//   Start    in  1  division request, sampled only in IDLE
//   A        in  W  dividend, captured on the accepting edge
//   B        in  W  divisor, captured on the accepting edge
//   Q        out W  quotient of the last division
//   R        out W  remainder of the last division
//   Busy     out 1  high while not in IDLE
//   Done     out 1  single-cycle result-valid pulse (the FIN cycle)
//   DivZero  out 1  last result came from a zero divisor
module divisor_4bits
    import divisor_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         Busy,
    output logic         Done,
    output logic         DivZero
);

    localparam int PW = W + 1;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

    div_state_e    state_q, state_d;
    logic [W-1:0]  d_q, d_d;       // dividend shift register, ends as quotient
    logic [W-1:0]  v_q, v_d;       // divisor
    logic [PW-1:0] p_q, p_d;       // partial remainder
    logic [CW-1:0] cnt_q, cnt_d;   // iterations remaining minus one
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  r_q, r_d;
    logic          dz_q, dz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [PW-1:0] trial;
    logic [PW-1:0] diff;
    logic [PW-1:0] rem_next;
    logic [W-1:0]  d_shift;
    logic          no_borrow;

    // Bring down the next dividend bit. P never exceeds W significant bits
    // between iterations, so the truncation only drops a bit known to be 0.
    assign trial = PW'({p_q, d_q[W-1]});

    subtrator_nbits #(
        .N (PW)
    ) u_sub (
        .X        (trial),
        .Y        ({1'b0, v_q}),
        .Diff     (diff),
        .NoBorrow (no_borrow)
    );

    // Restore on borrow; the quotient bit enters at the LSB of D.
    assign rem_next = no_borrow ? diff : trial;
    assign d_shift  = W'({d_q, no_borrow});

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        v_d     = v_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    d_d     = A;
                    v_d     = B;
                    p_d     = '0;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (v_q == '0) begin
                    // Zero divisor: one RUN cycle, then report all-ones
                    // quotient and the untouched dividend as remainder.
                    q_d     = '1;
                    r_d     = d_q;
                    dz_d    = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    p_d   = rem_next;
                    d_d   = d_shift;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        q_d     = d_shift;
                        r_d     = rem_next[W-1:0];
                        dz_d    = 1'b0;
                        state_d = ST_FIN;
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            v_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            v_q     <= v_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q       = q_q;
    assign R       = r_q;
    assign DivZero = dz_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule : divisor_4bits

// File: tb/tb_divisor_4bits.sv
// tb_divisor_4bits
// Directed self-checking bench for the sequential restoring divider.
module tb_divisor_4bits;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         Busy;
    logic         Done;
    logic         DivZero;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    divisor_4bits #(.W(W)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Q       (Q),
        .R       (R),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero)
    );

    always #5 Clk = ~Clk;

    // Done is high for a whole cycle, so every pulse spans one falling edge.
    always @(negedge Clk) if (Done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present a request for exactly one rising edge (edge k), then scramble
    // the operands since they are don't-care afterwards.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        A     = a;
        B     = b;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
    endtask

    // Edges after edge k until Done is seen; -1 if it never comes.
    task automatic wait_done(output int lat);
        int c = 0;
        while (Done !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        lat = (Done === 1'b1) ? c : -1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) tick();
        n_tests++; if (Q !== 4'd0)     begin n_fail++; $display("FAIL reset_q: got %0d want 0", Q); end
        n_tests++; if (R !== 4'd0)     begin n_fail++; $display("FAIL reset_r: got %0d want 0", R); end
        n_tests++; if (Busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_tests++; if (Done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
        n_tests++; if (DivZero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", DivZero); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        start_op(4'd13, 4'd4);
        n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b want 1", Busy); end
        n_tests++; if (Q !== 4'd0)    begin n_fail++; $display("FAIL basic_q_hold: got %0d want 0", Q); end
        wait_done(lat);
        n_tests++; if (lat != 4)      begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
        n_tests++; if (Q !== 4'd3)    begin n_fail++; $display("FAIL basic_q: got %0d want 3", Q); end
        n_tests++; if (R !== 4'd1)    begin n_fail++; $display("FAIL basic_r: got %0d want 1", R); end
        n_tests++; if (DivZero !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b want 0", DivZero); end
        n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_fin: got %b want 1", Busy); end
        tick();
        n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL basic_done_fall: got %b want 0", Done); end
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b want 0", Busy); end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(4'd15, 4'd1);
        wait_done(lat);
        n_tests++; if (lat != 4)   begin n_fail++; $display("FAIL b2b_lat1: got %0d want 4", lat); end
        n_tests++; if (Q !== 4'd15) begin n_fail++; $display("FAIL b2b_q1: got %0d want 15", Q); end
        n_tests++; if (R !== 4'd0)  begin n_fail++; $display("FAIL b2b_r1: got %0d want 0", R); end
        tick();
        n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL b2b_done1_width: got %b want 0", Done); end
        // First IDLE cycle after FIN: request is accepted immediately.
        start_op(4'd3, 4'd9);
        n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b want 1", Busy); end
        n_tests++; if (Q !== 4'd15)   begin n_fail++; $display("FAIL b2b_q_hold: got %0d want 15", Q); end
        wait_done(lat);
        n_tests++; if (lat != 4)   begin n_fail++; $display("FAIL b2b_lat2: got %0d want 4", lat); end
        n_tests++; if (Q !== 4'd0)  begin n_fail++; $display("FAIL b2b_q2: got %0d want 0", Q); end
        n_tests++; if (R !== 4'd3)  begin n_fail++; $display("FAIL b2b_r2: got %0d want 3", R); end
        tick();
        n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL b2b_done2_width: got %b want 0", Done); end
    endtask

    task automatic test_div_zero();
        int lat;
        start_op(4'd7, 4'd0);
        wait_done(lat);
        n_tests++; if (lat != 1)    begin n_fail++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_tests++; if (Q !== 4'd15) begin n_fail++; $display("FAIL dz_q: got %0d want 15", Q); end
        n_tests++; if (R !== 4'd7)  begin n_fail++; $display("FAIL dz_r: got %0d want 7", R); end
        n_tests++; if (DivZero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", DivZero); end
        tick();
        n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL dz_done_width: got %b want 0", Done); end
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy_fall: got %b want 0", Busy); end
        start_op(4'd9, 4'd3);
        wait_done(lat);
        n_tests++; if (lat != 4)    begin n_fail++; $display("FAIL dz_next_lat: got %0d want 4", lat); end
        n_tests++; if (Q !== 4'd3)  begin n_fail++; $display("FAIL dz_next_q: got %0d want 3", Q); end
        n_tests++; if (R !== 4'd0)  begin n_fail++; $display("FAIL dz_next_r: got %0d want 0", R); end
        n_tests++; if (DivZero !== 1'b0) begin n_fail++; $display("FAIL dz_next_flag: got %b want 0", DivZero); end
        tick();
    endtask

    task automatic test_ignore_start();
        int lat;
        int base;
        base = done_cnt;
        start_op(4'd14, 4'd3);
        tick();
        // Request mid-RUN with different operands; must be dropped.
        A     = 4'd1;
        B     = 4'd1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(lat);
        n_tests++; if (lat != 2)   begin n_fail++; $display("FAIL ign_latency: got %0d want 2", lat); end
        n_tests++; if (Q !== 4'd4) begin n_fail++; $display("FAIL ign_q: got %0d want 4", Q); end
        n_tests++; if (R !== 4'd2) begin n_fail++; $display("FAIL ign_r: got %0d want 2", R); end
        // Request during FIN is dropped too.
        A     = 4'd1;
        B     = 4'd1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL ign_fin_start: got busy %b want 0", Busy); end
        repeat (6) tick();
        n_tests++; if (done_cnt - base != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", done_cnt - base); end
        n_tests++; if (Q !== 4'd4) begin n_fail++; $display("FAIL ign_q_after: got %0d want 4", Q); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int base;
        base = done_cnt;
        start_op(4'd14, 4'd3);
        tick();
        tick();
        #2 Reset = 1'b1;
        #1;
        n_tests++; if (Q !== 4'd0)    begin n_fail++; $display("FAIL rst_run_q: got %0d want 0", Q); end
        n_tests++; if (R !== 4'd0)    begin n_fail++; $display("FAIL rst_run_r: got %0d want 0", R); end
        n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_run_busy: got %b want 0", Busy); end
        n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL rst_run_done: got %b want 0", Done); end
        #2 Reset = 1'b0;
        repeat (6) tick();
        n_tests++; if (done_cnt != base) begin n_fail++; $display("FAIL rst_run_no_done: got %0d pulses want 0", done_cnt - base); end
        n_tests++; if (Busy !== 1'b0)    begin n_fail++; $display("FAIL rst_run_idle: got %b want 0", Busy); end
        start_op(4'd9, 4'd2);
        wait_done(lat);
        n_tests++; if (lat != 4)   begin n_fail++; $display("FAIL rst_next_lat: got %0d want 4", lat); end
        n_tests++; if (Q !== 4'd4) begin n_fail++; $display("FAIL rst_next_q: got %0d want 4", Q); end
        n_tests++; if (R !== 4'd1) begin n_fail++; $display("FAIL rst_next_r: got %0d want 1", R); end
        tick();
    endtask

    task automatic test_sweep();
        int lat;
        int exp_q, exp_r, exp_lat;
        logic exp_dz;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) begin
                    exp_q = 15; exp_r = a; exp_dz = 1'b1; exp_lat = 1;
                end else begin
                    exp_q = a / b; exp_r = a % b; exp_dz = 1'b0; exp_lat = 4;
                end
                start_op(W'(a), W'(b));
                wait_done(lat);
                n_tests++; if (lat != exp_lat) begin n_fail++; $display("FAIL sweep_lat %0d/%0d: got %0d want %0d", a, b, lat, exp_lat); end
                n_tests++; if (Q !== W'(exp_q)) begin n_fail++; $display("FAIL sweep_q %0d/%0d: got %0d want %0d", a, b, Q, exp_q); end
                n_tests++; if (R !== W'(exp_r)) begin n_fail++; $display("FAIL sweep_r %0d/%0d: got %0d want %0d", a, b, R, exp_r); end
                n_tests++; if (DivZero !== exp_dz) begin n_fail++; $display("FAIL sweep_dz %0d/%0d: got %b want %b", a, b, DivZero, exp_dz); end
                tick();
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_reset_mid_run();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_divisor_4bits
